// File: rtl/spidergon_pkg.sv
// Shared types and routing helpers for the Spidergon NoC.
// Flit field widths are fixed here and cover up to 8 nodes with 16-bit flits.
package spidergon_pkg;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned PAY_W  = FLIT_W - 2 * ID_W;
  localparam int unsigned NPORTS = 4;
  localparam int unsigned VC0    = 0;
  localparam int unsigned VC1    = 1;

  // Input and output ports share one encoding; P_LOCAL is EJECT on the output side.
  typedef enum logic [1:0] {
    P_LOCAL  = 2'd0,
    P_CW     = 2'd1,
    P_CCW    = 2'd2,
    P_ACROSS = 2'd3
  } port_e;

  typedef struct packed {
    logic [ID_W-1:0]  dst;
    logic [ID_W-1:0]  src;
    logic [PAY_W-1:0] payload;
  } flit_t;

  function automatic port_e route(input int unsigned node, input int unsigned dst,
                                  input int unsigned n);
    int unsigned rel;
    rel = (dst + n - node) % n;
    if (rel == 0)              return P_LOCAL;
    else if (rel <= n / 4)     return P_CW;
    else if (rel >= (3*n) / 4) return P_CCW;
    else                       return P_ACROSS;
  endfunction

  // Dateline sits between node N-1 and node 0 in both ring directions.
  function automatic int unsigned next_vc(input int unsigned node, input port_e port,
                                          input int unsigned vc, input int unsigned n);
    if (port == P_ACROSS)                return VC0;
    if (port == P_CW  && node == n - 1)  return VC1;
    if (port == P_CCW && node == 0)      return VC1;
    return vc;
  endfunction

endpackage

// File: rtl/spidergon_noc_if.sv
// Point-to-point router link: one flit per cycle plus per-VC credit-free ready.
interface spidergon_noc_if #(
  parameter int unsigned VCS = 2
);
  import spidergon_pkg::*;

  localparam int unsigned VC_W = $clog2(VCS);

  logic            valid;
  logic [VC_W-1:0] vc;
  flit_t           flit;
  logic [VCS-1:0]  ready;

  modport master (output valid, vc, flit, input ready);
  modport slave  (input valid, vc, flit, output ready);
endinterface

// File: rtl/spidergon_node.sv
// One Spidergon router: per-port VC FIFOs, round-robin output arbiters,
// LFSR traffic generator on LOCAL and a checking sink on EJECT.
module spidergon_node
  import spidergon_pkg::*;
#(
  parameter int unsigned ID    = 0,
  parameter int unsigned NODES = 8,
  parameter int unsigned VCS   = 2,
  parameter int unsigned DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  spidergon_noc_if.master        cw_out,
  spidergon_noc_if.master        ccw_out,
  spidergon_noc_if.master        across_out,
  spidergon_noc_if.slave         cw_in,
  spidergon_noc_if.slave         ccw_in,
  spidergon_noc_if.slave         across_in,
  output logic                   inject_c,
  output logic                   eject_c,
  output logic                   misroute_c,
  output logic [NPORTS*VCS-1:0]  nonempty_c,
  output logic [NPORTS*VCS-1:0]  pop_c
);

  localparam int unsigned NREQ     = NPORTS * VCS;
  localparam int unsigned VC_W     = $clog2(VCS);
  localparam int unsigned RR_W     = $clog2(NREQ);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned B_CW     = VCS * 1;
  localparam int unsigned B_CCW    = VCS * 2;
  localparam int unsigned B_ACROSS = VCS * 3;

  // FIFO k holds input port k/VCS, virtual channel k%VCS.
  flit_t            mem    [NREQ][DEPTH];
  logic [PTR_W-1:0] rd_ptr [NREQ];
  logic [PTR_W-1:0] wr_ptr [NREQ];
  logic [CNT_W-1:0] cnt    [NREQ];
  logic [RR_W-1:0]  rr     [NPORTS];
  logic [7:0]       lfsr;
  logic [PAY_W-1:0] seq;

  logic [NREQ-1:0]   full, hv, push, pop;
  flit_t             hflit [NREQ];
  port_e             hport [NREQ];
  logic [VC_W-1:0]   hvc   [NREQ];
  logic [NREQ-1:0]   req   [NPORTS];
  logic [NPORTS-1:0] gnt;
  logic [RR_W-1:0]   win   [NPORTS];
  logic [VCS-1:0]    dn_rdy [NPORTS];
  logic [NPORTS-1:0] in_valid;
  logic [VC_W-1:0]   in_vc   [NPORTS];
  flit_t             in_flit [NPORTS];
  flit_t             gen_flit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign dn_rdy[P_LOCAL]  = '1;
  assign dn_rdy[P_CW]     = cw_out.ready;
  assign dn_rdy[P_CCW]    = ccw_out.ready;
  assign dn_rdy[P_ACROSS] = across_out.ready;

  assign in_valid[P_LOCAL]  = inject_c;
  assign in_vc[P_LOCAL]     = VC_W'(VC0);
  assign in_flit[P_LOCAL]   = gen_flit;
  assign in_valid[P_CW]     = cw_in.valid;
  assign in_vc[P_CW]        = cw_in.vc;
  assign in_flit[P_CW]      = cw_in.flit;
  assign in_valid[P_CCW]    = ccw_in.valid;
  assign in_vc[P_CCW]       = ccw_in.vc;
  assign in_flit[P_CCW]     = ccw_in.flit;
  assign in_valid[P_ACROSS] = across_in.valid;
  assign in_vc[P_ACROSS]    = across_in.vc;
  assign in_flit[P_ACROSS]  = across_in.flit;

  assign cw_in.ready     = ~full[B_CW +: VCS];
  assign ccw_in.ready    = ~full[B_CCW +: VCS];
  assign across_in.ready = ~full[B_ACROSS +: VCS];

  // Generator: inject into LOCAL VC0 whenever it has room.
  assign inject_c = !reset && !full[VC0];

  always_comb begin
    gen_flit.dst = lfsr[ID_W-1:0];
    if (gen_flit.dst == ID_W'(ID)) gen_flit.dst = ID_W'((ID + 1) % NODES);
    gen_flit.src     = ID_W'(ID);
    gen_flit.payload = seq;
  end

  // Head decode and per-output request vectors.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      full[k]  = (cnt[k] == CNT_W'(DEPTH));
      hv[k]    = (cnt[k] != '0);
      hflit[k] = mem[k][rd_ptr[k]];
      hport[k] = route(ID, 32'(hflit[k].dst), NODES);
      hvc[k]   = VC_W'(next_vc(ID, hport[k], 32'(k) % VCS, NODES));
      push[k]  = in_valid[k / VCS] && (in_vc[k / VCS] == VC_W'(k % VCS)) && !full[k];
    end
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int k = 0; k < NREQ; k++)
        req[o][k] = hv[k] && (hport[k] == port_e'(o)) && dn_rdy[o][hvc[k]];
    end
  end

  // Round-robin arbiters: first requester at or after the pointer wins.
  always_comb begin
    gnt = '0;
    pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      win[o] = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt[o] && req[o][(32'(rr[o]) + 32'(i)) % NREQ]) begin
          gnt[o] = 1'b1;
          win[o] = RR_W'((32'(rr[o]) + 32'(i)) % NREQ);
        end
      end
      if (gnt[o]) pop[win[o]] = 1'b1;
    end
  end

  assign cw_out.valid     = gnt[P_CW];
  assign cw_out.vc        = hvc[win[P_CW]];
  assign cw_out.flit      = hflit[win[P_CW]];
  assign ccw_out.valid    = gnt[P_CCW];
  assign ccw_out.vc       = hvc[win[P_CCW]];
  assign ccw_out.flit     = hflit[win[P_CCW]];
  assign across_out.valid = gnt[P_ACROSS];
  assign across_out.vc    = hvc[win[P_ACROSS]];
  assign across_out.flit  = hflit[win[P_ACROSS]];

  assign eject_c    = gnt[P_LOCAL];
  assign misroute_c = gnt[P_LOCAL] && (hflit[win[P_LOCAL]].dst != ID_W'(ID));
  assign nonempty_c = hv;
  assign pop_c      = pop;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NREQ; k++)
      if (push[k]) mem[k][wr_ptr[k]] <= in_flit[k / VCS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREQ; k++) begin
        cnt[k]    <= '0;
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
      for (int o = 0; o < NPORTS; o++) rr[o] <= '0;
      lfsr <= 8'(ID + 1);
      seq  <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (push[k]) wr_ptr[k] <= ptr_inc(wr_ptr[k]);
        if (pop[k])  rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        if (push[k] && !pop[k])      cnt[k] <= cnt[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) cnt[k] <= cnt[k] - CNT_W'(1);
      end
      for (int o = 0; o < NPORTS; o++)
        if (gnt[o]) rr[o] <= RR_W'((32'(win[o]) + 32'd1) % NREQ);
      if (inject_c) begin
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        seq  <= seq + PAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/spidergon_noc.sv
// Spidergon NoC top: N routers on a bidirectional ring plus across links,
// with network-wide injection/ejection counters and a sticky misroute flag.
module spidergon_noc
  import spidergon_pkg::*;
#(
  parameter int unsigned NUM_OF_NODES            = 8,
  parameter int unsigned FLIT_DATA_WIDTH         = 16,
  parameter int unsigned NODE_BUFFER_WIDTH       = 32,
  parameter int unsigned NUM_OF_VIRTUAL_CHANNELS = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] injected_count,
  output logic [31:0] delivered_count,
  output logic        routing_error
);

  localparam int unsigned RAW_DEPTH =
    NODE_BUFFER_WIDTH / (NUM_OF_VIRTUAL_CHANNELS * FLIT_DATA_WIDTH);
  localparam int unsigned DEPTH = (RAW_DEPTH < 1) ? 1 : RAW_DEPTH;
  localparam int unsigned NREQ  = NPORTS * NUM_OF_VIRTUAL_CHANNELS;

  logic [NUM_OF_NODES-1:0]           inj_v, ej_v, bad_v;
  logic [NUM_OF_NODES-1:0][NREQ-1:0] node_busy, node_pop;

  // Link i carries traffic leaving node i in that direction.
  spidergon_noc_if #(.VCS(NUM_OF_VIRTUAL_CHANNELS)) cw_link  [NUM_OF_NODES] ();
  spidergon_noc_if #(.VCS(NUM_OF_VIRTUAL_CHANNELS)) ccw_link [NUM_OF_NODES] ();
  spidergon_noc_if #(.VCS(NUM_OF_VIRTUAL_CHANNELS)) ac_link  [NUM_OF_NODES] ();

  for (genvar i = 0; i < NUM_OF_NODES; i++) begin : g_node
    spidergon_node #(
      .ID    (i),
      .NODES (NUM_OF_NODES),
      .VCS   (NUM_OF_VIRTUAL_CHANNELS),
      .DEPTH (DEPTH)
    ) u_node (
      .clk        (clk),
      .reset      (reset),
      .cw_out     (cw_link[i]),
      .ccw_out    (ccw_link[i]),
      .across_out (ac_link[i]),
      .cw_in      (cw_link[(i + NUM_OF_NODES - 1) % NUM_OF_NODES]),
      .ccw_in     (ccw_link[(i + 1) % NUM_OF_NODES]),
      .across_in  (ac_link[(i + NUM_OF_NODES / 2) % NUM_OF_NODES]),
      .inject_c   (inj_v[i]),
      .eject_c    (ej_v[i]),
      .misroute_c (bad_v[i]),
      .nonempty_c (node_busy[i]),
      .pop_c      (node_pop[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      injected_count  <= '0;
      delivered_count <= '0;
      routing_error   <= 1'b0;
    end else begin
      injected_count  <= injected_count  + 32'($countones(inj_v));
      delivered_count <= delivered_count + 32'($countones(ej_v));
      routing_error   <= routing_error | (|bad_v);
    end
  end

endmodule

// File: tb/tb_spidergon_noc.sv
// Directed bench for spidergon_noc: reset, routing table, startup traffic,
// VC placement, soak without deadlock and mid-run reset replay.
module tb_spidergon_noc;
  import spidergon_pkg::*;

  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] injected_count, delivered_count;
  logic        routing_error;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  spidergon_noc #(
    .NUM_OF_NODES            (8),
    .FLIT_DATA_WIDTH         (16),
    .NODE_BUFFER_WIDTH       (32),
    .NUM_OF_VIRTUAL_CHANNELS (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .injected_count  (injected_count),
    .delivered_count (delivered_count),
    .routing_error   (routing_error)
  );

  function automatic flit_t mkflit(input int unsigned d, input int unsigned s,
                                   input int unsigned p);
    flit_t f;
    f.dst = ID_W'(d);
    f.src = ID_W'(s);
    f.payload = PAY_W'(p);
    return f;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (injected_count !== 32'd0) $display("FAIL reset_inj got=%0d exp=0", injected_count);
    else passed++;
    total++;
    if (delivered_count !== 32'd0) $display("FAIL reset_del got=%0d exp=0", delivered_count);
    else passed++;
    total++;
    if (routing_error !== 1'b0) $display("FAIL reset_err got=%b exp=0", routing_error);
    else passed++;
    total++;
    if (dut.node_busy !== '0) $display("FAIL reset_fifos got=%h exp=0", dut.node_busy);
    else passed++;
  endtask

  task automatic test_route();
    port_e exp [8];
    port_e got;
    exp = '{P_LOCAL, P_CW, P_CW, P_ACROSS, P_ACROSS, P_ACROSS, P_CCW, P_CCW};
    for (int d = 0; d < 8; d++) begin
      got = route(0, d, N);
      total++;
      if (got !== exp[d]) $display("FAIL route_0_to_%0d got=%0d exp=%0d", d, got, exp[d]);
      else passed++;
    end
    got = route(4, 3, N);
    total++;
    if (got !== P_CCW) $display("FAIL route_4_to_3 got=%0d exp=%0d", got, P_CCW);
    else passed++;
    got = route(4, 5, N);
    total++;
    if (got !== P_CW) $display("FAIL route_4_to_5 got=%0d exp=%0d", got, P_CW);
    else passed++;
    total++;
    if (next_vc(7, P_CW, 0, N) !== 1) $display("FAIL vc_cw_dateline got=%0d exp=1", next_vc(7, P_CW, 0, N));
    else passed++;
    total++;
    if (next_vc(0, P_CCW, 0, N) !== 1) $display("FAIL vc_ccw_dateline got=%0d exp=1", next_vc(0, P_CCW, 0, N));
    else passed++;
    total++;
    if (next_vc(3, P_ACROSS, 1, N) !== 0) $display("FAIL vc_across got=%0d exp=0", next_vc(3, P_ACROSS, 1, N));
    else passed++;
    total++;
    if (next_vc(2, P_CW, 1, N) !== 1) $display("FAIL vc_keep got=%0d exp=1", next_vc(2, P_CW, 1, N));
    else passed++;
  endtask

  // First four edges after reset release; every node's first flit is a 1-hop CW.
  task automatic test_startup(input string tag);
    flit_t f;
    flit_t e;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (injected_count !== 32'd8) $display("FAIL %s_e1_inj got=%0d exp=8", tag, injected_count);
    else passed++;
    total++;
    if (delivered_count !== 32'd0) $display("FAIL %s_e1_del got=%0d exp=0", tag, delivered_count);
    else passed++;

    @(posedge clk); #1;
    total++;
    if (injected_count !== 32'd8) $display("FAIL %s_e2_inj got=%0d exp=8", tag, injected_count);
    else passed++;
    total++;
    if (delivered_count !== 32'd0) $display("FAIL %s_e2_del got=%0d exp=0", tag, delivered_count);
    else passed++;
    total++;
    if (int'(dut.g_node[0].u_node.cnt[3]) != 1 || int'(dut.g_node[0].u_node.cnt[2]) != 0)
      $display("FAIL %s_dateline_vc got_vc1=%0d got_vc0=%0d exp_vc1=1 exp_vc0=0", tag,
               dut.g_node[0].u_node.cnt[3], dut.g_node[0].u_node.cnt[2]);
    else passed++;
    f = dut.g_node[0].u_node.mem[3][0];
    e = mkflit(0, 7, 0);
    total++;
    if (f !== e) $display("FAIL %s_dateline_flit got=%h exp=%h", tag, f, e);
    else passed++;
    f = dut.g_node[1].u_node.mem[2][0];
    e = mkflit(1, 0, 0);
    total++;
    if (int'(dut.g_node[1].u_node.cnt[2]) != 1 || f !== e)
      $display("FAIL %s_ring_vc0 got=%h exp=%h", tag, f, e);
    else passed++;

    @(posedge clk); #1;
    total++;
    if (injected_count !== 32'd16) $display("FAIL %s_e3_inj got=%0d exp=16", tag, injected_count);
    else passed++;
    total++;
    if (delivered_count !== 32'd8) $display("FAIL %s_e3_del got=%0d exp=8", tag, delivered_count);
    else passed++;

    @(posedge clk); #1;
    total++;
    if (injected_count !== 32'd16) $display("FAIL %s_e4_inj got=%0d exp=16", tag, injected_count);
    else passed++;
    total++;
    if (delivered_count !== 32'd8) $display("FAIL %s_e4_del got=%0d exp=8", tag, delivered_count);
    else passed++;
    f = dut.g_node[5].u_node.mem[6][0];
    e = mkflit(4, 1, 1);
    total++;
    if (int'(dut.g_node[5].u_node.cnt[6]) != 1 || f !== e)
      $display("FAIL %s_across_vc0 got=%h exp=%h", tag, f, e);
    else passed++;
  endtask

  task automatic test_soak();
    int          stall [N][NREQ];
    int          max_stall;
    logic [31:0] prev;
    max_stall = 0;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < NREQ; k++) stall[n][k] = 0;
    prev = delivered_count;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int n = 0; n < N; n++)
        for (int k = 0; k < NREQ; k++) begin
          if (dut.node_busy[n][k] && !dut.node_pop[n][k]) stall[n][k]++;
          else stall[n][k] = 0;
          if (stall[n][k] > max_stall) max_stall = stall[n][k];
        end
      @(posedge clk); #1;
      total++;
      if (routing_error !== 1'b0) $display("FAIL soak_err cyc=%0d got=%b exp=0", c, routing_error);
      else passed++;
      total++;
      if (injected_count - delivered_count > 32'd64)
        $display("FAIL soak_inflight cyc=%0d got=%0d exp<=64", c, injected_count - delivered_count);
      else passed++;
      total++;
      if (delivered_count < prev)
        $display("FAIL soak_monotonic cyc=%0d got=%0d exp>=%0d", c, delivered_count, prev);
      else passed++;
      prev = delivered_count;
    end
    total++;
    if (max_stall > 16) $display("FAIL soak_stall got=%0d exp<=16", max_stall);
    else passed++;
    total++;
    if (delivered_count <= 32'd8) $display("FAIL soak_progress got=%0d exp>8", delivered_count);
    else passed++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (injected_count !== 32'd0 || delivered_count !== 32'd0)
      $display("FAIL midreset_counts got=%0d/%0d exp=0/0", injected_count, delivered_count);
    else passed++;
    total++;
    if (routing_error !== 1'b0) $display("FAIL midreset_err got=%b exp=0", routing_error);
    else passed++;
    total++;
    if (dut.node_busy !== '0) $display("FAIL midreset_fifos got=%h exp=0", dut.node_busy);
    else passed++;
    test_startup("rerun");
  endtask

  initial begin
    test_reset();
    test_route();
    test_startup("first");
    test_soak();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spidergon_noc.md
Name: spidergon_noc

Overview:
Self-contained Spidergon network-on-chip: NUM_OF_NODES routers on a bidirectional ring, each also linked to the node opposite it (i+N/2).
Each node has a built-in LFSR traffic generator and a checking sink, so only clock and reset are mandatory inputs.
Used as a top-level traffic and deadlock-freedom testbed. Status counters are exported for checking.

Parameters:
NUM_OF_NODES, 8, node count; even, at least 4, power of two.
FLIT_DATA_WIDTH, 16, flit width: [W-1 -: log2N] dst, next log2N src, remaining bits payload.
NODE_BUFFER_WIDTH, 32, storage bits per input port. Per-VC depth = NODE_BUFFER_WIDTH/(NUM_OF_VIRTUAL_CHANNELS*FLIT_DATA_WIDTH), at least 1.
NUM_OF_VIRTUAL_CHANNELS, 2, VCs per input port; minimum 2 (dateline).

Ports:
clk  input  1  single clock, all state on rising edge.
reset  input  1  synchronous active-high reset.
injected_count  output  32  total flits injected, all nodes.
delivered_count  output  32  total flits ejected, all nodes.
routing_error  output  1  sticky; a flit was ejected at a node other than its dst.

Behaviour:
- Reset, sampled on clk:
  - All VC buffers empty; all counters and routing_error 0.
  - Node i LFSR (8-bit, x^8+x^6+x^5+x^4+1) = i+1; per-node sequence counter 0.
  - Asserting reset mid-traffic discards every in-flight flit.
- Per node: 4 input ports (LOCAL, CW_IN, CCW_IN, ACROSS_IN) and 4 output ports (EJECT, CW, CCW, ACROSS), each input port with NUM_OF_VIRTUAL_CHANNELS FIFOs.
- Routing, computed at the buffer head. rel = (dst - node) mod N:
  - rel = 0 → EJECT.
  - 1 ≤ rel ≤ N/4 → CW.
  - rel ≥ 3N/4 → CCW.
  - Otherwise → ACROSS.
  - Across is therefore taken at most once, always as the first hop.
- VC rule:
  - Injection and every across hop place the flit in VC0.
  - A ring hop crossing the dateline (CW N-1→0, or CCW 0→N-1) moves the flit to VC1; other ring hops keep the VC.
- Flow control:
  - Each link carries valid, vc, flit.
  - Downstream ready per VC = that FIFO not full, evaluated from the registered state. A flit may not enter and leave the same FIFO in one cycle.
  - EJECT is always ready.
- Arbitration: per output, round-robin over all (input port, VC) heads requesting it. The pointer advances past the winner on a grant. At most one flit per output per cycle; each input VC head sends at most one flit per cycle.
- Timing:
  - A granted flit is written into the next node's FIFO at the same edge it is popped, giving 1 cycle per hop.
  - Ejection is counted at the edge the EJECT grant pops the flit.
  - Uncontended latency, injection edge to ejection edge = hops+1 cycles.
- Generator, every cycle after reset deasserts:
  - Injects if the LOCAL VC0 FIFO is not full.
  - dst = LFSR[log2N-1:0]; if dst equals own id, dst = (id+1) mod N.
  - payload = sequence counter (truncated).
  - The LFSR steps and the sequence counter increments only on injection.
- Sink: on ejection, increment delivered_count and set routing_error if dst ≠ node id.
- Counters wrap at 2^32. Simultaneous injections/ejections across nodes are all summed in the same cycle.
- Invariant: injected_count - delivered_count ≤ N*4*VCs*depth.

Decomposition:
- Package spidergon_pkg holds:
  - Port enum (LOCAL/CW/CCW/ACROSS).
  - Flit field-width localparams and the flit struct.
  - VC index constants.
  - Pure function route(node, dst, N) returning the output port.
  - Function next_vc(node, port, vc).
- One sub-module, spidergon_node: FIFOs, arbiters, generator and sink. The top instantiates N of them and wires CW/CCW/across links modulo N.

Test Plan:
- Hold reset 2 cycles → all counters 0, routing_error 0, all FIFOs empty.
- route() table for N=8:
  - 0→0 EJECT
  - 0→1 CW
  - 0→2 CW
  - 0→7 CCW
  - 0→6 CCW
  - 0→3 ACROSS (then 4→3 CCW)
  - 0→4 ACROSS
  - 0→5 ACROSS (then 4→5 CW)
- Release reset → injected_count = 8 at the first active edge. delivered_count > 0 within 4 cycles and non-decreasing.
- Run 30 cycles → routing_error 0; injected - delivered ≤ 64; no (node, VC) FIFO head stalled more than 16 consecutive cycles (no deadlock).
- Flit crossing node 7→0 CW → arrives in node 0 CW_IN VC1; a flit entering via ACROSS_IN → VC0.
- Assert reset for 1 cycle mid-run → next cycle counters 0 and FIFOs empty; traffic resumes identically to the first run (same dst sequence).
